// File: rtl/video_pkg.sv
// Shared types and default 720x480p timing for the video timing generator.
// Also provides the counter-width helper used by the top and the counter.
package video_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEF_H_ACTIVE = 720;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 62;
   localparam int DEF_H_BP     = 60;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 9;
   localparam int DEF_V_SYNC   = 6;
   localparam int DEF_V_BP     = 30;

   // Width needed to count 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/video_wrap_counter.sv
// Modulo-MAX counter: counts 0..MAX-1 while en is high.
// The wrap pulse marks the enabled cycle on which count returns to 0.
module video_wrap_counter
   import video_pkg::*;
#(
   parameter int MAX = 8,
   parameter int W   = cnt_w(MAX)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] count,
   output logic         wrap
);

   assign wrap = en && (count == W'(MAX - 1));

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= wrap ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: walks h/v counters over the full frame, pulls
// pixels from upstream in the active area and emits registered HDMI-style video.
module video_timing_gen
   import video_pkg::*;
#(
   parameter int               DATA_W   = 36,
   parameter int               H_ACTIVE = DEF_H_ACTIVE,
   parameter int               H_FP     = DEF_H_FP,
   parameter int               H_SYNC   = DEF_H_SYNC,
   parameter int               H_BP     = DEF_H_BP,
   parameter int               V_ACTIVE = DEF_V_ACTIVE,
   parameter int               V_FP     = DEF_V_FP,
   parameter int               V_SYNC   = DEF_V_SYNC,
   parameter int               V_BP     = DEF_V_BP,
   parameter logic             HS_POL   = 1'b0,
   parameter logic             VS_POL   = 1'b0,
   parameter logic [DATA_W-1:0] UF_COLOR = '0
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               en,
   input  logic [DATA_W-1:0]                                  in_data,
   input  logic                                               in_valid,
   output logic                                               in_ready,
   output logic [DATA_W-1:0]                                  hdmi_data,
   output logic                                               hdmi_hsync,
   output logic                                               hdmi_vsync,
   output logic                                               hdmi_en,
   output logic                                               hdmi_clk,
   output logic [cnt_w(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]        h_pos,
   output logic [cnt_w(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]        v_pos,
   output logic                                               frame_start,
   output logic                                               underflow
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = cnt_w(H_TOTAL);
   localparam int VW      = cnt_w(V_TOTAL);

   state_t         state, state_nxt;
   logic           run;
   logic [HW-1:0]  h_cnt;
   logic [VW-1:0]  v_cnt;
   logic           h_wrap, v_wrap;
   logic           active, hs_on, vs_on;

   assign run = (state == ST_RUN);

   video_wrap_counter #(.MAX(H_TOTAL), .W(HW)) u_h_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (run),
      .clr   (~run),
      .count (h_cnt),
      .wrap  (h_wrap)
   );

   video_wrap_counter #(.MAX(V_TOTAL), .W(VW)) u_v_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (h_wrap),
      .clr   (~run),
      .count (v_cnt),
      .wrap  (v_wrap)
   );

   // v_wrap is only high on the last pixel of the last line.
   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      case (state)
         ST_IDLE: if (en)              state_nxt = ST_RUN;
         ST_RUN:  if (v_wrap && !en)   state_nxt = ST_IDLE;
         default:                      state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   assign active = run && (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
   assign hs_on  = run && (h_cnt >= HW'(H_ACTIVE + H_FP))
                       && (h_cnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
   assign vs_on  = run && (v_cnt >= VW'(V_ACTIVE + V_FP))
                       && (v_cnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));

   assign in_ready = active;
   assign hdmi_clk = clk;

   // Output stage: one register of latency from the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         hdmi_data   <= '0;
         hdmi_en     <= 1'b0;
         hdmi_hsync  <= ~HS_POL;
         hdmi_vsync  <= ~VS_POL;
         h_pos       <= '0;
         v_pos       <= '0;
         frame_start <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         hdmi_en     <= active;
         hdmi_data   <= !active ? '0 : (in_valid ? in_data : UF_COLOR);
         underflow   <= active && !in_valid;
         hdmi_hsync  <= hs_on ? HS_POL : ~HS_POL;
         hdmi_vsync  <= vs_on ? VS_POL : ~VS_POL;
         h_pos       <= h_cnt;
         v_pos       <= v_cnt;
         frame_start <= run && (h_cnt == '0) && (v_cnt == '0);
      end
   end

endmodule
